button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised, per-channel front end for the puzzle's push-buttons. It replaces the bare rising-edge detector with a full conditioning chain.
- Each channel gets a 2-FF synchroniser, a counter debouncer, press and release pulses, a long-press level and auto-repeat pulses.
- Sits between the board button pins and the game FSM. All outputs are synchronous to `clock`, and every event output is a single-cycle pulse.

Parameters:
- N_BUTTONS, 8, number of independent button channels (1..32).
- DEBOUNCE_CYCLES, 4, consecutive clock edges of a changed synchronised value needed to accept a new level (>=1).
- HOLD_CYCLES, 10, clock edges after an accepted press before `long_press` asserts and the first repeat pulse fires (>=1).
- REPEAT_CYCLES, 3, clock edges between consecutive repeat pulses while held (>=1).

Ports:
- clock  in  1  system clock; everything is clocked on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- botoes  in  N_BUTTONS  raw, asynchronous, bouncing button inputs; 1 = pressed.
- repeat_en  in  N_BUTTONS  per-channel auto-repeat enable, synchronous.
- level  out  N_BUTTONS  debounced button state.
- press  out  N_BUTTONS  one-cycle pulse on an accepted 0->1 transition of `level`.
- release  out  N_BUTTONS  one-cycle pulse on an accepted 1->0 transition of `level`.
- long_press  out  N_BUTTONS  high while a channel has been held for at least HOLD_CYCLES.
- repeat  out  N_BUTTONS  auto-repeat pulses, gated by `repeat_en`.
- any_event  out  1  registered OR of all `press` and `release` bits of the same cycle.

Behaviour:
- Reset is asynchronous and active-high: reset reset, asynchronous, active-high; clock clock.
- On reset, every output is 0. Synchroniser flops, stable levels, debounce counters and hold counters are also 0.
- Synchroniser: sync1 <= botoes, then sync2 <= sync1, per bit.
- Debounce, per channel, with `stable` driving `level`:
  - If sync2 == stable, the counter is cleared to 0.
  - Otherwise the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, `stable` takes sync2 and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES edges therefore produces no event and no level change.
- Latency: a raw change that is set up before edge E0 and stays stable appears on `level`/`press`/`release` at edge E0+DEBOUNCE_CYCLES+1.
- `press` and `release` are registered. They assert on the same edge that `stable` changes, for exactly one cycle. They can never both be high on one channel.
- Per-channel hold FSM, with states IDLE, HOLDING, LONG:
  - IDLE -> HOLDING on the press edge P. The hold counter is loaded to 0 and counts one per edge.
  - HOLDING -> LONG at edge P+HOLD_CYCLES. At that edge `long_press` rises, and `repeat` pulses if repeat_en is 1; the repeat counter is cleared.
  - In LONG, `repeat` pulses at P+HOLD_CYCLES+k*REPEAT_CYCLES for k>=1, while repeat_en is 1. The repeat counter keeps running when repeat_en is 0, so re-enabling stays phase-aligned.
  - Any state -> IDLE on the release edge. `long_press` drops on the release edge, counters clear, and no repeat fires on that edge.
  - A release before P+HOLD_CYCLES gives no `long_press` and no `repeat`.
- Counter widths are $clog2(param+1) bits. The hold counter stops once LONG is reached, and the repeat counter wraps at REPEAT_CYCLES. No overflow is possible.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle.
- `any_event` is registered from the same-cycle press|release vector, so it lags those pulses by one cycle.
- Reset mid-operation: all state clears immediately. A button still held when reset deasserts is seen as a new press at the DEBOUNCE_CYCLES+1 latency.

Decomposition:
- Shared constants file: default N_BUTTONS, DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES values for the board clock, and the hold-FSM state encodings (IDLE=2'd0, HOLDING=2'd1, LONG=2'd2).
- Sub-module `button_channel`: one bit's synchroniser, debouncer and hold FSM. It is instantiated N_BUTTONS times in a generate loop. The top level holds only the generate loop and the `any_event` register.

Test Plan:
- Default parameters. Clean press of botoes[2] held for 8 cycles, then released → `level[2]` rises at E0+5; `press[2]` pulses that cycle; `release[2]` pulses 5 edges after the raw fall; `any_event` follows each pulse by 1 cycle; `long_press` stays 0.
- Bounce pattern 1,0,1,1,0 on botoes[0], then steady 0 → no `press`, `level[0]` stays 0. Steady 1 for 4 edges after the bounce → a single `press`.
- Hold botoes[5] for 20 cycles with repeat_en=8'hFF. Press at edge P → `long_press[5]` at P+10; `repeat[5]` at P+10, P+13, P+16; after release, no further repeats and `long_press` clears on the release edge.
- Same hold with repeat_en[5]=0 → `long_press` asserts at P+10 and `repeat[5]` stays 0. Set repeat_en[5]=1 at P+14 → next `repeat[5]` at P+16.
- botoes=8'hFF applied simultaneously → `press`=8'hFF for one cycle, `any_event` one cycle later. Simultaneous press on bit 1 and release on bit 6 → both pulses appear in the same cycle.
- Assert `reset` while bit 3 is in LONG with the button still held → all outputs 0 immediately. After reset deasserts, `press[3]` pulses at DEBOUNCE_CYCLES+1 edges.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioning chain: board default
// timing parameters and the per-channel hold-FSM state encoding.
package button_conditioner_pkg;

  localparam int DEF_N_BUTTONS       = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 10;
  localparam int DEF_REPEAT_CYCLES   = 3;

  typedef enum logic [1:0] {
    HOLD_IDLE    = 2'd0,
    HOLD_HOLDING = 2'd1,
    HOLD_LONG    = 2'd2
  } hold_state_t;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, counter debouncer with press/release
// pulses, and a hold FSM producing the long-press level and auto-repeat pulses.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_stable;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_press;
  logic              r_release;
  hold_state_t       r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic              r_long;
  logic              r_repeat;

  logic [DB_W-1:0]   w_db_inc;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              w_hold_done;
  logic [REP_W-1:0]  w_rep_inc;
  logic              w_rep_wrap;
  hold_state_t       w_state_next;
  logic [HOLD_W-1:0] w_hold_next;
  logic [REP_W-1:0]  w_rep_next;
  logic              w_long_next;
  logic              w_repeat_next;

  // A new level is accepted on the edge where the disagreement count would reach the limit.
  assign w_db_inc    = r_db_cnt + DB_W'(1);
  assign w_accept    = (r_sync2 != r_stable) && (w_db_inc == DB_W'(DEBOUNCE_CYCLES));
  assign w_rise      = w_accept && r_sync2;
  assign w_fall      = w_accept && !r_sync2;
  assign w_hold_inc  = r_hold_cnt + HOLD_W'(1);
  assign w_hold_done = (w_hold_inc == HOLD_W'(HOLD_CYCLES));
  assign w_rep_inc   = r_rep_cnt + REP_W'(1);
  assign w_rep_wrap  = (w_rep_inc == REP_W'(REPEAT_CYCLES));

  // Synchroniser, debouncer and registered press/release pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_db_cnt  <= {DB_W{1'b0}};
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_button;
      r_sync2   <= r_sync1;
      r_press   <= w_rise;
      r_release <= w_fall;
      if (r_sync2 == r_stable) begin
        r_db_cnt <= {DB_W{1'b0}};
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_db_cnt <= {DB_W{1'b0}};
      end else begin
        r_db_cnt <= w_db_inc;
      end
    end
  end

  // Hold FSM state register, including its counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= HOLD_IDLE;
      r_hold_cnt <= {HOLD_W{1'b0}};
      r_rep_cnt  <= {REP_W{1'b0}};
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_rep_cnt  <= w_rep_next;
      r_long     <= w_long_next;
      r_repeat   <= w_repeat_next;
    end
  end

  // Hold FSM next state; a release edge overrides everything else.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_rep_next   = r_rep_cnt;
    if (w_fall) begin
      w_state_next = HOLD_IDLE;
      w_hold_next  = {HOLD_W{1'b0}};
      w_rep_next   = {REP_W{1'b0}};
    end else begin
      case (r_state)
        HOLD_IDLE: begin
          if (w_rise) begin
            w_state_next = HOLD_HOLDING;
            w_hold_next  = {HOLD_W{1'b0}};
            w_rep_next   = {REP_W{1'b0}};
          end else begin
            w_state_next = HOLD_IDLE;
          end
        end
        HOLD_HOLDING: begin
          if (w_hold_done) begin
            w_state_next = HOLD_LONG;
            w_rep_next   = {REP_W{1'b0}};
          end else begin
            w_hold_next  = w_hold_inc;
          end
        end
        HOLD_LONG: begin
          // Repeat phase keeps running regardless of the enable so re-enabling stays aligned.
          if (w_rep_wrap) begin
            w_rep_next = {REP_W{1'b0}};
          end else begin
            w_rep_next = w_rep_inc;
          end
        end
        default: begin
          w_state_next = HOLD_IDLE;
          w_hold_next  = {HOLD_W{1'b0}};
          w_rep_next   = {REP_W{1'b0}};
        end
      endcase
    end
  end

  // Hold FSM outputs, computed for the edge being taken.
  always_comb begin
    w_long_next   = 1'b0;
    w_repeat_next = 1'b0;
    if (w_fall) begin
      w_long_next   = 1'b0;
      w_repeat_next = 1'b0;
    end else begin
      case (r_state)
        HOLD_IDLE: begin
          w_long_next   = 1'b0;
          w_repeat_next = 1'b0;
        end
        HOLD_HOLDING: begin
          w_long_next   = w_hold_done;
          w_repeat_next = w_hold_done && i_repeat_en;
        end
        HOLD_LONG: begin
          w_long_next   = 1'b1;
          w_repeat_next = w_rep_wrap && i_repeat_en;
        end
        default: begin
          w_long_next   = 1'b0;
          w_repeat_next = 1'b0;
        end
      endcase
    end
  end

  assign o_level      = r_stable;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long;
  assign o_repeat     = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: one conditioning channel per button
// plus a registered any-event flag for the game FSM.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BUTTONS       = DEF_N_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] i_botoes,
  input  logic [N_BUTTONS-1:0] i_repeat_en,
  output logic [N_BUTTONS-1:0] o_level,
  output logic [N_BUTTONS-1:0] o_press,
  output logic [N_BUTTONS-1:0] o_release,
  output logic [N_BUTTONS-1:0] o_long_press,
  output logic [N_BUTTONS-1:0] o_repeat,
  output logic                 o_any_event
);

  logic r_any_event;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .i_button     (i_botoes[g]),
      .i_repeat_en  (i_repeat_en[g]),
      .o_level      (o_level[g]),
      .o_press      (o_press[g]),
      .o_release    (o_release[g]),
      .o_long_press (o_long_press[g]),
      .o_repeat     (o_repeat[g])
    );
  end

  // Any press or release this cycle, flagged one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_any_event <= 1'b0;
    end else begin
      r_any_event <= |(o_press | o_release);
    end
  end

  assign o_any_event = r_any_event;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a timing-rule model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_button_conditioner;

  localparam int NB = 8;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int R  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] botoes;
  logic [NB-1:0] repeat_en;
  logic [NB-1:0] level, press, rel, long_press, rpt;
  logic          any_event;

  int errors = 0;
  int checks = 0;

  // Model state: rule-level description of each channel.
  int unsigned   m_cyc;
  logic [NB-1:0] m_s1, m_s2, m_stable, m_press, m_rel, m_long, m_rep, m_held;
  logic          m_any;
  int            m_run [NB];
  int            m_p   [NB];

  button_conditioner #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_botoes     (botoes),
    .i_repeat_en  (repeat_en),
    .o_level      (level),
    .o_press      (press),
    .o_release    (rel),
    .o_long_press (long_press),
    .o_repeat     (rpt),
    .o_any_event  (any_event)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_rel = '0;
    m_long = '0; m_rep = '0; m_held = '0; m_any = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_p[i]   = 0;
    end
  endtask

  // Advance the model by one rising edge, using the inputs seen at that edge.
  task automatic model_step();
    bit ev;
    int el;
    m_cyc++;
    m_any = |(m_press | m_rel);
    for (int i = 0; i < NB; i++) begin
      ev = 1'b0;
      if (m_s2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_stable[i] = m_s2[i];
          m_run[i]    = 0;
          ev          = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      m_press[i] = ev && m_stable[i];
      m_rel[i]   = ev && !m_stable[i];
      if (m_press[i]) begin
        m_held[i] = 1'b1;
        m_p[i]    = int'(m_cyc);
      end
      if (m_rel[i]) m_held[i] = 1'b0;
      el = int'(m_cyc) - m_p[i];
      m_long[i] = m_held[i] && (el >= H);
      m_rep[i]  = m_held[i] && (el >= H) && (((el - H) % R) == 0) && repeat_en[i];
    end
    m_s2 = m_s1;
    m_s1 = botoes;
  endtask

  task automatic compare_all();
    chk("level", level, m_stable);
    chk("press", press, m_press);
    chk("release", rel, m_rel);
    chk("long_press", long_press, m_long);
    chk("repeat", rpt, m_rep);
    chk("any_event", {7'd0, any_event}, {7'd0, m_any});
  endtask

  // One clock cycle: update the model for the edge just taken and compare.
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (reset) model_reset();
      else model_step();
      compare_all();
    end
  endtask

  initial begin
    reset     = 1'b1;
    botoes    = 8'h00;
    repeat_en = 8'h00;
    model_reset();
    steps(3);
    chk("reset_level", level, 8'h00);
    chk("reset_any", {7'd0, any_event}, 8'h00);
    reset = 1'b0;

    // Clean press of bit 2, held 8 edges.
    botoes[2] = 1'b1;
    steps(5);
    chk("t1_level_early", {7'd0, level[2]}, 8'h00);
    steps(1);
    chk("t1_level", {7'd0, level[2]}, 8'h01);
    chk("t1_press", press, 8'h04);
    chk("t1_model_press", m_press, 8'h04);
    steps(1);
    chk("t1_any", {7'd0, any_event}, 8'h01);
    chk("t1_press_gone", press, 8'h00);
    steps(1);
    botoes[2] = 1'b0;
    steps(5);
    chk("t1_rel_early", rel, 8'h00);
    steps(1);
    chk("t1_release", rel, 8'h04);
    chk("t1_level_low", level, 8'h00);
    steps(1);
    chk("t1_any_rel", {7'd0, any_event}, 8'h01);
    chk("t1_no_long", long_press, 8'h00);
    steps(6);

    // Bounce 1,0,1,1,0 on bit 0, then steady.
    botoes[0] = 1'b1; steps(1);
    botoes[0] = 1'b0; steps(1);
    botoes[0] = 1'b1; steps(1);
    steps(1);
    botoes[0] = 1'b0;
    steps(12);
    chk("t2_bounce_level", level, 8'h00);
    botoes[0] = 1'b1;
    steps(6);
    chk("t2_press", press, 8'h01);
    steps(4);
    botoes[0] = 1'b0;
    steps(10);

    // Long hold of bit 5 with repeats enabled; P = press edge.
    repeat_en = 8'hFF;
    botoes[5] = 1'b1;
    steps(6);
    chk("t3_press", press, 8'h20);
    steps(9);
    chk("t3_long_early", long_press, 8'h00);
    steps(1);
    chk("t3_long", long_press, 8'h20);
    chk("t3_rep10", rpt, 8'h20);
    chk("t3_model_rep10", m_rep, 8'h20);
    steps(1);
    chk("t3_rep11", rpt, 8'h00);
    steps(2);
    chk("t3_rep13", rpt, 8'h20);
    steps(3);
    chk("t3_rep16", rpt, 8'h20);
    botoes[5] = 1'b0;
    steps(5);
    chk("t3_long_before_rel", long_press, 8'h20);
    steps(1);
    chk("t3_release", rel, 8'h20);
    chk("t3_long_drop", long_press, 8'h00);
    chk("t3_no_rep_on_rel", rpt, 8'h00);
    steps(8);

    // Same hold with repeat disabled on bit 5, enabled from P+14.
    repeat_en = 8'hDF;
    botoes[5] = 1'b1;
    steps(6);
    chk("t4_press", press, 8'h20);
    steps(10);
    chk("t4_long", long_press, 8'h20);
    chk("t4_rep_masked", rpt, 8'h00);
    steps(3);
    chk("t4_rep13_masked", rpt, 8'h00);
    repeat_en = 8'hFF;
    steps(3);
    chk("t4_rep16", rpt, 8'h20);
    botoes[5] = 1'b0;
    steps(12);

    // All buttons at once, then simultaneous press/release on different bits.
    botoes = 8'hFF;
    steps(6);
    chk("t5_press_all", press, 8'hFF);
    steps(1);
    chk("t5_any", {7'd0, any_event}, 8'h01);
    chk("t5_press_gone", press, 8'h00);
    botoes = 8'h40;
    steps(16);
    botoes = 8'h02;
    steps(6);
    chk("t5_press1", press, 8'h02);
    chk("t5_release6", rel, 8'h40);
    steps(1);
    chk("t5_any2", {7'd0, any_event}, 8'h01);
    steps(4);

    // Reset while bit 3 is in LONG and still held.
    botoes = 8'h08;
    steps(16);
    chk("t6_long3", long_press, 8'h08);
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_level", level, 8'h00);
    chk("t6_rst_long", long_press, 8'h00);
    chk("t6_rst_press", press | rel | rpt, 8'h00);
    steps(2);
    reset = 1'b0;
    steps(5);
    chk("t6_press_early", press, 8'h00);
    steps(1);
    chk("t6_press3", press, 8'h08);
    steps(15);
    botoes = 8'h00;
    steps(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
